mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified byte-addressed memory between the instruction-fetch requester and the load/store requester.
- Both requesters use valid/ready request handshakes. The block sequences one access at a time onto the memory's shared address/control/data port.
- It returns each result as a one-cycle response pulse to the owning requester.
- It sits between the core's fetch/LSU stages and the memory.

Parameters:
- MEM_LAT, 1: cycles the memory port is held per access before mem_dout is sampled; legal range 1..15.
- STARVE_MAX, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  64  fetch byte address
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  64  fetched data
- dm_req_valid  in  1  load/store request valid
- dm_req_ready  out  1  load/store request accepted this cycle
- dm_req_addr  in  64  data byte address
- dm_req_rd_ctrl  in  3  load type: 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, other none
- dm_req_wr_ctrl  in  2  store type: 01 sb, 10 sh, 11 sw, 00 none
- dm_req_wdata  in  64  store data
- dm_rsp_valid  out  1  load/store response pulse (stores too)
- dm_rsp_data  out  64  load data; 0 for stores
- mem_addr  out  64  memory address
- mem_rd_ctrl  out  3  memory read control
- mem_wr_ctrl  out  2  memory write control
- mem_din  out  64  memory write data
- mem_dout  in  64  memory read data, combinational from mem_addr/mem_rd_ctrl

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high.
- Reset values:
  - state=IDLE, starve_cnt=0, all outputs 0.
  - Reset mid-transaction drops the in-flight access: no response is issued, and mem_wr_ctrl is 0 from the reset cycle on.
- State IDLE:
  - Arbitrates combinationally. Ready is asserted only to the winner.
  - Data wins by default. Fetch wins if dm_req_valid=0, or if starve_cnt==STARVE_MAX and if_req_valid=1.
  - On valid&ready, latch the request (addr, ctrl, wdata) and go to ACCESS with lat_cnt=MEM_LAT-1.
  - Both readies are 0 in every other state.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on a data grant while if_req_valid=1.
  - Clears on any fetch grant.
  - Holds otherwise.
- State ACCESS:
  - mem_addr/mem_rd_ctrl/mem_din are driven from the latched request. A fetch drives mem_rd_ctrl=101 and mem_wr_ctrl=00.
  - mem_wr_ctrl carries the latched store type only on the first ACCESS cycle and is 00 on later ACCESS cycles, so exactly one write edge occurs per store.
  - If the latched wr_ctrl is nonzero, mem_rd_ctrl=000; the write takes precedence.
  - lat_cnt decrements each cycle. When lat_cnt==0, sample mem_dout into the response register and go to IDLE.
- Response:
  - The owner's rsp_valid pulses exactly one cycle: the first IDLE cycle after ACCESS.
  - rsp_data holds its value until the next response.
  - A load with rd_ctrl outside 001..101 and wr_ctrl=00 is a no-op that is still acknowledged, with data 0.
- Timing:
  - Request accepted at cycle T gives ACCESS at T+1..T+MEM_LAT and rsp_valid at T+MEM_LAT+1.
  - A new grant may occur in the response cycle, giving a peak throughput of 1 access per MEM_LAT+1 cycles.
- Outside ACCESS, mem_rd_ctrl=000 and mem_wr_ctrl=00. mem_addr/mem_din hold their last values.
- Requests must hold valid and payload stable until ready. The block does not buffer unaccepted requests.

Decomposition:
- Shared package holds:
  - rd_ctrl codes (LB=001, LBU=010, LH=011, LHU=100, LW=101, RD_NONE=000)
  - wr_ctrl codes (SB=01, SH=10, SW=11, WR_NONE=00)
  - state enum (IDLE, ACCESS)
  - owner enum (OWN_IF, OWN_DM)
- The arbitration and starvation counter form one natural sub-module, mem_arb_prio: inputs are the two valids and a grant-enable; outputs are the grant and the starvation flag. Everything else stays in the top-level block.

Test Plan:
- Single fetch, MEM_LAT=1: if_req_addr=0x40 accepted at T, memory returns 0x00000013 -> mem_rd_ctrl=101 at T+1, if_rsp_valid=1 and if_rsp_data=0x13 at T+2, dm_rsp_valid stays 0.
- Store then load, MEM_LAT=2: sw addr 0x100 data 0xDEADBEEF -> mem_wr_ctrl=11 for exactly 1 cycle; dm_rsp_valid at T+3 with data 0; following lw 0x100 -> dm_rsp_data=0xDEADBEEF.
- Simultaneous valid in IDLE, starve_cnt=0: dm_req_ready=1 and if_req_ready=0; fetch is granted in the response cycle of the data access.
- Starvation, STARVE_MAX=4: both valid continuously -> grant pattern DM,DM,DM,DM,IF,DM…; starve_cnt returns to 0 after the IF grant.
- Reset mid-ACCESS (MEM_LAT=3, sb in flight, rst at T+2) -> no dm_rsp_valid, mem_wr_ctrl=00 from T+2, all outputs 0 on the cycle after rst.
- No-op request dm_req_rd_ctrl=111 with wr_ctrl=00 -> accepted, mem_wr_ctrl=00 throughout, dm_rsp_valid pulses with data 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared codes and enums for the fetch / load-store memory port arbiter.
//   - rd_ctrl codes (3 bit) and wr_ctrl codes (2 bit) of the memory port
//   - FSM state enum and access owner enum
//   - helper that decides whether a rd_ctrl code names a real load
package mem_port_arbiter_pkg;

   localparam logic [2:0] RD_NONE = 3'b000;
   localparam logic [2:0] RD_LB   = 3'b001;
   localparam logic [2:0] RD_LBU  = 3'b010;
   localparam logic [2:0] RD_LH   = 3'b011;
   localparam logic [2:0] RD_LHU  = 3'b100;
   localparam logic [2:0] RD_LW   = 3'b101;

   localparam logic [1:0] WR_NONE = 2'b00;
   localparam logic [1:0] WR_SB   = 2'b01;
   localparam logic [1:0] WR_SH   = 2'b10;
   localparam logic [1:0] WR_SW   = 2'b11;

   localparam int unsigned LAT_W = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Codes 110/111 are not loads; such a request is acknowledged as a no-op.
   function automatic logic is_load(input logic [2:0] rd);
      return (rd >= RD_LB) && (rd <= RD_LW);
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio
// Fixed-priority arbiter (data first) with a starvation counter that forces
// the fetch requester to win after STARVE_MAX consecutive data grants made
// while fetch was waiting.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_if_valid            fetch request valid
//   i_dm_valid            load/store request valid
//   i_grant_en            arbitration allowed this cycle (port idle)
//   o_gnt_if, o_gnt_dm    one-hot grant (only to a valid requester)
//   o_starved             starvation counter has reached STARVE_MAX
module mem_arb_prio #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_if_valid,
   input  logic i_dm_valid,
   input  logic i_grant_en,
   output logic o_gnt_if,
   output logic o_gnt_dm,
   output logic o_starved
);

   logic [3:0] r_starve_cnt;

   assign o_starved = (r_starve_cnt == 4'(STARVE_MAX));

   always_comb begin
      o_gnt_if = 1'b0;
      o_gnt_dm = 1'b0;
      if (i_grant_en) begin
         if (i_if_valid && (!i_dm_valid || o_starved)) begin
            o_gnt_if = 1'b1;
         end else if (i_dm_valid) begin
            o_gnt_dm = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_starve_cnt <= '0;
      end else if (o_gnt_if) begin
         r_starve_cnt <= '0;
      end else if (o_gnt_dm && i_if_valid && !o_starved) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one byte-addressed memory port between instruction fetch and the
// load/store unit. One access at a time is held on the port for MEM_LAT
// cycles, then the result is returned as a one-cycle response pulse.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_if_req_*/o_if_req_ready        fetch request handshake (address only)
//   o_if_rsp_valid/o_if_rsp_data     fetch response pulse and held data
//   i_dm_req_*/o_dm_req_ready        load/store request handshake
//   o_dm_rsp_valid/o_dm_rsp_data     load/store response (data 0 for stores)
//   o_mem_addr/rd_ctrl/wr_ctrl/din   memory port controls
//   i_mem_dout                       memory read data (combinational)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_if_req_valid,
   output logic        o_if_req_ready,
   input  logic [63:0] i_if_req_addr,
   output logic        o_if_rsp_valid,
   output logic [63:0] o_if_rsp_data,
   input  logic        i_dm_req_valid,
   output logic        o_dm_req_ready,
   input  logic [63:0] i_dm_req_addr,
   input  logic [2:0]  i_dm_req_rd_ctrl,
   input  logic [1:0]  i_dm_req_wr_ctrl,
   input  logic [63:0] i_dm_req_wdata,
   output logic        o_dm_rsp_valid,
   output logic [63:0] o_dm_rsp_data,
   output logic [63:0] o_mem_addr,
   output logic [2:0]  o_mem_rd_ctrl,
   output logic [1:0]  o_mem_wr_ctrl,
   output logic [63:0] o_mem_din,
   input  logic [63:0] i_mem_dout
);

   state_e           r_state;
   state_e           w_state_d;
   owner_e           r_owner;
   logic [LAT_W-1:0] r_lat_cnt;
   logic             r_first;
   logic [63:0]      r_addr;
   logic [2:0]       r_rd_ctrl;
   logic [1:0]       r_wr_ctrl;
   logic [63:0]      r_wdata;
   logic             r_if_rsp_valid;
   logic             r_dm_rsp_valid;
   logic [63:0]      r_if_rsp_data;
   logic [63:0]      r_dm_rsp_data;

   logic             w_grant_en;
   logic             w_gnt_if;
   logic             w_gnt_dm;
   logic             w_starved;
   logic             w_done;
   logic [63:0]      w_rsp_sample;

   // Readies are held low during reset so nothing is accepted that cycle.
   assign w_grant_en = (r_state == ST_IDLE) && !i_rst;
   assign w_done     = (r_state == ST_ACCESS) && (r_lat_cnt == '0);

   mem_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_if_valid (i_if_req_valid),
      .i_dm_valid (i_dm_req_valid),
      .i_grant_en (w_grant_en),
      .o_gnt_if   (w_gnt_if),
      .o_gnt_dm   (w_gnt_dm),
      .o_starved  (w_starved)
   );

   // Starvation state only steers the grant inside mem_arb_prio.
   logic w_unused;
   assign w_unused = w_starved;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_gnt_if || w_gnt_dm) w_state_d = ST_ACCESS;
         ST_ACCESS: if (r_lat_cnt == '0)      w_state_d = ST_IDLE;
         default:   w_state_d = ST_IDLE;
      endcase
   end

   // Stores and no-op loads answer with 0 rather than whatever the port returns.
   always_comb begin
      w_rsp_sample = i_mem_dout;
      if ((r_wr_ctrl != WR_NONE) || (r_rd_ctrl == RD_NONE)) begin
         w_rsp_sample = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner        <= OWN_IF;
         r_lat_cnt      <= '0;
         r_first        <= 1'b0;
         r_addr         <= '0;
         r_rd_ctrl      <= RD_NONE;
         r_wr_ctrl      <= WR_NONE;
         r_wdata        <= '0;
         r_if_rsp_valid <= 1'b0;
         r_dm_rsp_valid <= 1'b0;
         r_if_rsp_data  <= '0;
         r_dm_rsp_data  <= '0;
      end else begin
         r_if_rsp_valid <= 1'b0;
         r_dm_rsp_valid <= 1'b0;
         if (w_gnt_if) begin
            r_owner   <= OWN_IF;
            r_addr    <= i_if_req_addr;
            r_rd_ctrl <= RD_LW;
            r_wr_ctrl <= WR_NONE;
            r_lat_cnt <= LAT_W'(MEM_LAT - 1);
            r_first   <= 1'b1;
         end else if (w_gnt_dm) begin
            r_owner   <= OWN_DM;
            r_addr    <= i_dm_req_addr;
            r_rd_ctrl <= is_load(i_dm_req_rd_ctrl) ? i_dm_req_rd_ctrl : RD_NONE;
            r_wr_ctrl <= i_dm_req_wr_ctrl;
            r_wdata   <= i_dm_req_wdata;
            r_lat_cnt <= LAT_W'(MEM_LAT - 1);
            r_first   <= 1'b1;
         end else if (r_state == ST_ACCESS) begin
            r_first   <= 1'b0;
            r_lat_cnt <= r_lat_cnt - 1'b1;
         end
         if (w_done) begin
            if (r_owner == OWN_IF) begin
               r_if_rsp_valid <= 1'b1;
               r_if_rsp_data  <= w_rsp_sample;
            end else begin
               r_dm_rsp_valid <= 1'b1;
               r_dm_rsp_data  <= w_rsp_sample;
            end
         end
      end
   end

   always_comb begin
      o_mem_rd_ctrl = RD_NONE;
      o_mem_wr_ctrl = WR_NONE;
      if ((r_state == ST_ACCESS) && !i_rst) begin
         // A store owns the port; its read control is suppressed.
         if (r_wr_ctrl == WR_NONE) o_mem_rd_ctrl = r_rd_ctrl;
         // Write only on the first access cycle so each store writes once.
         if (r_first) o_mem_wr_ctrl = r_wr_ctrl;
      end
   end

   assign o_mem_addr     = r_addr;
   assign o_mem_din      = r_wdata;
   assign o_if_req_ready = w_gnt_if;
   assign o_dm_req_ready = w_gnt_dm;
   assign o_if_rsp_valid = r_if_rsp_valid;
   assign o_dm_rsp_valid = r_dm_rsp_valid;
   assign o_if_rsp_data  = r_if_rsp_data;
   assign o_dm_rsp_data  = r_dm_rsp_data;

endmodule
